// File: rtl/lsu.sv
// lsu: MEM-stage load/store unit issuing one outstanding valid/ready bus access per instruction.
// Build option LSU_MISALIGN_TRAP_EN: misaligned half/word accesses raise fault_o instead of being realigned.
module lsu #(
    parameter int CTRL_WIDTH = 16,
    parameter int XLEN       = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic [CTRL_WIDTH-1:0] ctrl_i,
    input  logic [2:0]            funct3_i,
    input  logic [XLEN-1:0]       addr_i,
    input  logic [XLEN-1:0]       wdata_i,
    output logic                  stall_o,
    output logic                  wb_valid_o,
    output logic [XLEN-1:0]       rdata_o,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic                  fault_o,
`endif
    output logic                  req_valid_o,
    input  logic                  req_ready_i,
    output logic                  req_we_o,
    output logic [XLEN-1:0]       req_addr_o,
    output logic [XLEN-1:0]       req_wdata_o,
    output logic [3:0]            req_wstrb_o,
    input  logic                  rsp_valid_i,
    input  logic [XLEN-1:0]       rsp_rdata_i,
    output logic [1:0]            state_o
);

    // Handshake: a request transfers on the edge where req_valid_o & req_ready_i; fields hold
    // while valid is up. rsp_valid_i is a single-cycle acknowledge honoured only in S_WAIT.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    state_e          state_q;
    logic            req_valid_q;
    logic            req_we_q;
    logic [XLEN-1:0] req_addr_q;
    logic [XLEN-1:0] req_wdata_q;
    logic [3:0]      req_wstrb_q;
    logic            wb_valid_q;
    logic [XLEN-1:0] rdata_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic [1:0]      off_q;
`ifdef LSU_MISALIGN_TRAP_EN
    logic            fault_q;
`endif

    logic            mem_re;
    logic            mem_we;
    logic            start;
    logic            ctrl_unused;

    logic [1:0]      size_d;
    logic            uns_d;
    logic [1:0]      off_d;
    logic            we_d;
    logic [XLEN-1:0] req_addr_d;
    logic [XLEN-1:0] req_wdata_d;
    logic [3:0]      req_wstrb_d;
`ifdef LSU_MISALIGN_TRAP_EN
    logic            misalign_d;
`endif

    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] load_data;

    assign mem_re      = ctrl_i[3];
    assign mem_we      = ctrl_i[2];
    assign start       = valid_i & (mem_re | mem_we);
    assign ctrl_unused = ^{ctrl_i[CTRL_WIDTH-1:4], ctrl_i[1:0]};

    // Request decode from the live inputs; consumed only on the start edge.
    always_comb begin
        size_d      = SZ_W;
        uns_d       = funct3_i[2];
        off_d       = 2'b00;
        we_d        = mem_we & ~mem_re;
        req_addr_d  = {addr_i[XLEN-1:2], 2'b00};
        req_wdata_d = '0;
        req_wstrb_d = 4'b0000;

        if (!funct3_i[1]) begin
            size_d = funct3_i[0] ? SZ_H : SZ_B;
        end

        // Low address bits that do not fit the access size are dropped.
        case (size_d)
            SZ_B:    off_d = addr_i[1:0];
            SZ_H:    off_d = {addr_i[1], 1'b0};
            default: off_d = 2'b00;
        endcase

        if (we_d) begin
            case (size_d)
                SZ_B: begin
                    req_wdata_d = {4{wdata_i[7:0]}};
                    req_wstrb_d = 4'b0001 << off_d;
                end
                SZ_H: begin
                    req_wdata_d = {2{wdata_i[15:0]}};
                    req_wstrb_d = 4'b0011 << off_d;
                end
                default: begin
                    req_wdata_d = wdata_i;
                    req_wstrb_d = 4'b1111;
                end
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_d = ((size_d == SZ_H) && addr_i[0]) ||
                        ((size_d == SZ_W) && (addr_i[1:0] != 2'b00));
`endif

    // Lane extraction for the returning read word.
    always_comb begin
        byte_sel  = rsp_rdata_i[{off_q, 3'b000} +: 8];
        half_sel  = rsp_rdata_i[{off_q[1], 4'b0000} +: 16];
        load_data = rsp_rdata_i;
        case (size_q)
            SZ_B: load_data = uns_q ? {{(XLEN-8){1'b0}}, byte_sel}
                                    : {{(XLEN-8){byte_sel[7]}}, byte_sel};
            SZ_H: load_data = uns_q ? {{(XLEN-16){1'b0}}, half_sel}
                                    : {{(XLEN-16){half_sel[15]}}, half_sel};
            default: load_data = rsp_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            req_valid_q <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wstrb_q <= 4'b0000;
            wb_valid_q  <= 1'b0;
            rdata_q     <= '0;
            size_q      <= SZ_W;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
`ifdef LSU_MISALIGN_TRAP_EN
            fault_q     <= 1'b0;
`endif
        end else begin
            wb_valid_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            fault_q    <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (start) begin
`ifdef LSU_MISALIGN_TRAP_EN
                        if (misalign_d) begin
                            state_q    <= S_DONE;
                            wb_valid_q <= 1'b1;
                            fault_q    <= 1'b1;
                        end else
`endif
                        begin
                            state_q     <= S_REQ;
                            req_valid_q <= 1'b1;
                            req_we_q    <= we_d;
                            req_addr_q  <= req_addr_d;
                            req_wdata_q <= req_wdata_d;
                            req_wstrb_q <= req_wstrb_d;
                            size_q      <= size_d;
                            uns_q       <= uns_d;
                            off_q       <= off_d;
                        end
                    end
                end
                S_REQ: begin
                    if (req_ready_i) begin
                        state_q     <= S_WAIT;
                        req_valid_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (rsp_valid_i) begin
                        state_q    <= S_DONE;
                        wb_valid_q <= 1'b1;
                        if (!req_we_q) begin
                            rdata_q <= load_data;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign stall_o     = ((state_q == S_IDLE) && start) || (state_q == S_REQ) || (state_q == S_WAIT);
    assign wb_valid_o  = wb_valid_q;
    assign rdata_o     = rdata_q;
    assign req_valid_o = req_valid_q;
    assign req_we_o    = req_we_q;
    assign req_addr_o  = req_addr_q;
    assign req_wdata_o = req_wdata_q;
    assign req_wstrb_o = req_wstrb_q;
    assign state_o     = state_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign fault_o     = fault_q;
`endif

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed self-checking bench for the lsu load/store unit (honours LSU_MISALIGN_TRAP_EN).
module tb_lsu;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic        clk;
    logic        rst_i;
    logic        valid_i;
    logic [15:0] ctrl_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        stall_o;
    logic        wb_valid_o;
    logic [31:0] rdata_o;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        fault_o;
`endif
    logic        req_valid_o;
    logic        req_ready_i;
    logic        req_we_o;
    logic [31:0] req_addr_o;
    logic [31:0] req_wdata_o;
    logic [3:0]  req_wstrb_o;
    logic        rsp_valid_i;
    logic [31:0] rsp_rdata_i;
    logic [1:0]  state_o;

    int          n_checks;
    int          n_fail;
    logic [31:0] last_load;

    lsu #(.CTRL_WIDTH(16), .XLEN(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .ctrl_i      (ctrl_i),
        .funct3_i    (funct3_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .stall_o     (stall_o),
        .wb_valid_o  (wb_valid_o),
        .rdata_o     (rdata_o),
`ifdef LSU_MISALIGN_TRAP_EN
        .fault_o     (fault_o),
`endif
        .req_valid_o (req_valid_o),
        .req_ready_i (req_ready_i),
        .req_we_o    (req_we_o),
        .req_addr_o  (req_addr_o),
        .req_wdata_o (req_wdata_o),
        .req_wstrb_o (req_wstrb_o),
        .rsp_valid_i (rsp_valid_i),
        .rsp_rdata_i (rsp_rdata_i),
        .state_o     (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [15:0] c, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd);
        valid_i  = 1'b1;
        ctrl_i   = c;
        funct3_i = f3;
        addr_i   = a;
        wdata_i  = wd;
    endtask

    task automatic drive_bus(input logic rdy, input logic rv, input logic [31:0] rd);
        req_ready_i = rdy;
        rsp_valid_i = rv;
        rsp_rdata_i = rd;
    endtask

    task automatic drive_idle();
        valid_i = 1'b0;
        ctrl_i  = 16'h0000;
        drive_bus(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        drive_idle();
        repeat (3) step();
        @(negedge clk);
        n_checks++; if ({stall_o, wb_valid_o, req_valid_o, req_we_o} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctl: got %b want 0000", {stall_o, wb_valid_o, req_valid_o, req_we_o}); end
        n_checks++; if (req_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", req_addr_o); end
        n_checks++; if (req_wdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", req_wdata_o); end
        n_checks++; if (req_wstrb_o !== 4'h0) begin n_fail++; $display("FAIL reset_wstrb: got %h want 0", req_wstrb_o); end
        n_checks++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata_o); end
        n_checks++; if (state_o !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", state_o, ST_IDLE); end
`ifdef LSU_MISALIGN_TRAP_EN
        n_checks++; if (fault_o !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", fault_o); end
`endif
        step();
        rst_i = 1'b0;
    endtask

    // Control words without mem_re/mem_we, or valid_i low, must never start an access.
    task automatic test_no_start();
        step();
        drive_op(16'hFFF3, 3'b010, 32'h100, 32'h0);
        drive_bus(1'b1, 1'b1, 32'h0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++; if ({stall_o, state_o} !== {1'b0, ST_IDLE}) begin n_fail++; $display("FAIL nostart_ctrl c%0d: got %b/%0d want 0/0", c, stall_o, state_o); end
            step();
        end
        valid_i = 1'b0;
        ctrl_i  = 16'h0008;
        @(negedge clk);
        n_checks++; if ({stall_o, state_o} !== {1'b0, ST_IDLE}) begin n_fail++; $display("FAIL nostart_valid: got %b/%0d want 0/0", stall_o, state_o); end
        step();
        @(negedge clk);
        n_checks++; if (state_o !== ST_IDLE) begin n_fail++; $display("FAIL nostart_valid_state: got %0d want 0", state_o); end
        drive_idle();
    endtask

    task automatic test_lw();
        step();
        drive_op(16'h0008, 3'b010, 32'h100, 32'h0);
        drive_bus(1'b1, 1'b1, 32'hDEADBEEF);
        @(negedge clk);
        n_checks++; if ({stall_o, req_valid_o, state_o} !== {1'b1, 1'b0, ST_IDLE}) begin n_fail++; $display("FAIL lw_c0: got %b%b/%0d want 10/0", stall_o, req_valid_o, state_o); end
        step();
        @(negedge clk);
        n_checks++; if ({stall_o, req_valid_o, req_we_o, state_o} !== {3'b110, ST_REQ}) begin n_fail++; $display("FAIL lw_c1: got %b%b%b/%0d want 110/1", stall_o, req_valid_o, req_we_o, state_o); end
        n_checks++; if (req_addr_o !== 32'h100) begin n_fail++; $display("FAIL lw_addr: got %h want 00000100", req_addr_o); end
        n_checks++; if (req_wstrb_o !== 4'b0000) begin n_fail++; $display("FAIL lw_wstrb: got %b want 0000", req_wstrb_o); end
        step();
        @(negedge clk);
        n_checks++; if ({stall_o, req_valid_o, wb_valid_o, state_o} !== {3'b100, ST_WAIT}) begin n_fail++; $display("FAIL lw_c2: got %b%b%b/%0d want 100/2", stall_o, req_valid_o, wb_valid_o, state_o); end
        step();
        @(negedge clk);
        n_checks++; if ({stall_o, wb_valid_o, state_o} !== {2'b01, ST_DONE}) begin n_fail++; $display("FAIL lw_c3: got %b%b/%0d want 01/3", stall_o, wb_valid_o, state_o); end
        n_checks++; if (rdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_rdata: got %h want deadbeef", rdata_o); end
        step();
        drive_idle();
        @(negedge clk);
        n_checks++; if ({wb_valid_o, state_o} !== {1'b0, ST_IDLE}) begin n_fail++; $display("FAIL lw_c4: got %b/%0d want 0/0", wb_valid_o, state_o); end
        last_load = 32'hDEADBEEF;
    endtask

    task automatic test_load_ext();
        logic [15:0] v_ctrl [8];
        logic [2:0]  v_f3   [8];
        logic [31:0] v_addr [8];
        logic [31:0] v_word [8];
        logic [31:0] v_exp  [8];
        logic [31:0] v_radr [8];
        v_ctrl = '{16'h0008, 16'h0008, 16'h0008, 16'h0008, 16'h000C, 16'h0008, 16'hFFF8, 16'h0008};
        v_f3   = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b001, 3'b011, 3'b110, 3'b000};
        v_addr = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h200, 32'h204, 32'h208, 32'h102};
        v_word = '{32'h80FF0000, 32'h80FF0000, 32'h80FF0000, 32'h80FF0000, 32'h12347FFE, 32'hCAFEF00D, 32'h11223344, 32'h00550000};
        v_exp  = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF, 32'hFFFF80FF, 32'h00007FFE, 32'hCAFEF00D, 32'h11223344, 32'h00000055};
        v_radr = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h200, 32'h204, 32'h208, 32'h100};
        for (int i = 0; i < 8; i++) begin
            step();
            drive_op(v_ctrl[i], v_f3[i], v_addr[i], 32'hFFFFFFFF);
            drive_bus(1'b1, 1'b1, v_word[i]);
            step();
            @(negedge clk);
            n_checks++; if ({req_valid_o, req_we_o, req_wstrb_o} !== 6'b100000) begin n_fail++; $display("FAIL ld%0d_req: got %b%b%b want 100000", i, req_valid_o, req_we_o, req_wstrb_o); end
            n_checks++; if (req_addr_o !== v_radr[i]) begin n_fail++; $display("FAIL ld%0d_addr: got %h want %h", i, req_addr_o, v_radr[i]); end
            step();
            step();
            @(negedge clk);
            n_checks++; if (wb_valid_o !== 1'b1) begin n_fail++; $display("FAIL ld%0d_wb: got %b want 1", i, wb_valid_o); end
            n_checks++; if (rdata_o !== v_exp[i]) begin n_fail++; $display("FAIL ld%0d_rdata: got %h want %h", i, rdata_o, v_exp[i]); end
            step();
            drive_idle();
        end
        last_load = 32'h00000055;
    endtask

    task automatic test_store();
        logic [2:0]  v_f3   [3];
        logic [31:0] v_addr [3];
        logic [31:0] v_wd   [3];
        logic [31:0] v_radr [3];
        logic [31:0] v_rwd  [3];
        logic [3:0]  v_strb [3];
        v_f3   = '{3'b000, 3'b001, 3'b010};
        v_addr = '{32'h201, 32'h302, 32'h404};
        v_wd   = '{32'h123456A5, 32'hCAFEBEEF, 32'h89ABCDEF};
        v_radr = '{32'h200, 32'h300, 32'h404};
        v_rwd  = '{32'hA5A5A5A5, 32'hBEEFBEEF, 32'h89ABCDEF};
        v_strb = '{4'b0010, 4'b1100, 4'b1111};
        for (int i = 0; i < 3; i++) begin
            step();
            drive_op(16'h0004, v_f3[i], v_addr[i], v_wd[i]);
            drive_bus(1'b1, 1'b1, 32'h5A5A5A5A);
            step();
            @(negedge clk);
            n_checks++; if ({req_valid_o, req_we_o} !== 2'b11) begin n_fail++; $display("FAIL st%0d_req: got %b%b want 11", i, req_valid_o, req_we_o); end
            n_checks++; if (req_addr_o !== v_radr[i]) begin n_fail++; $display("FAIL st%0d_addr: got %h want %h", i, req_addr_o, v_radr[i]); end
            n_checks++; if (req_wstrb_o !== v_strb[i]) begin n_fail++; $display("FAIL st%0d_wstrb: got %b want %b", i, req_wstrb_o, v_strb[i]); end
            n_checks++; if (req_wdata_o !== v_rwd[i]) begin n_fail++; $display("FAIL st%0d_wdata: got %h want %h", i, req_wdata_o, v_rwd[i]); end
            step();
            step();
            @(negedge clk);
            n_checks++; if (wb_valid_o !== 1'b1) begin n_fail++; $display("FAIL st%0d_wb: got %b want 1", i, wb_valid_o); end
            n_checks++; if (rdata_o !== last_load) begin n_fail++; $display("FAIL st%0d_rdata_kept: got %h want %h", i, rdata_o, last_load); end
            step();
            drive_idle();
        end
    endtask

    // Ready held off for three REQ cycles, response two WAIT cycles late, stray response in REQ.
    task automatic test_stall();
        logic [1:0] exp_st;
        for (int c = 0; c <= 9; c++) begin
            step();
            if (c == 0) drive_op(16'h0008, 3'b010, 32'h400, 32'h0);
            if (c == 9) valid_i = 1'b0;
            drive_bus(c == 4, (c == 2) || (c == 7), (c == 2) ? 32'hBAD0BAD0 : 32'h13579BDF);
            exp_st = (c == 0 || c == 9) ? ST_IDLE : (c <= 4) ? ST_REQ : (c <= 7) ? ST_WAIT : ST_DONE;
            @(negedge clk);
            n_checks++; if (state_o !== exp_st) begin n_fail++; $display("FAIL stall_state c%0d: got %0d want %0d", c, state_o, exp_st); end
            n_checks++; if ({stall_o, wb_valid_o, req_valid_o} !== {c <= 7, c == 8, (c >= 1) && (c <= 4)}) begin n_fail++; $display("FAIL stall_ctl c%0d: got %b%b%b", c, stall_o, wb_valid_o, req_valid_o); end
            if (c >= 1 && c <= 8) begin
                n_checks++; if ({req_addr_o, req_we_o, req_wstrb_o} !== {32'h400, 1'b0, 4'b0000}) begin n_fail++; $display("FAIL stall_fields c%0d: got %h %b %b want 00000400 0 0000", c, req_addr_o, req_we_o, req_wstrb_o); end
            end
            if (c == 8) begin
                n_checks++; if (rdata_o !== 32'h13579BDF) begin n_fail++; $display("FAIL stall_rdata: got %h want 13579bdf", rdata_o); end
            end
        end
        drive_idle();
        last_load = 32'h13579BDF;
    endtask

    // Instruction held across DONE: the next start is the cycle after DONE, not DONE itself.
    task automatic test_back_to_back();
        for (int c = 0; c <= 8; c++) begin
            step();
            if (c == 0) drive_op(16'h0008, 3'b010, 32'h600, 32'h0);
            if (c == 4) drive_op(16'h0008, 3'b100, 32'h605, 32'h0);
            if (c == 8) valid_i = 1'b0;
            drive_bus(1'b1, 1'b1, (c < 4) ? 32'h01020304 : 32'hAABBCCDD);
            @(negedge clk);
            n_checks++; if (state_o !== ((c == 8) ? ST_IDLE : 2'(c % 4))) begin n_fail++; $display("FAIL b2b_state c%0d: got %0d want %0d", c, state_o, (c == 8) ? 0 : c % 4); end
            n_checks++; if ({stall_o, wb_valid_o} !== {(c != 3) && (c != 7) && (c != 8), (c == 3) || (c == 7)}) begin n_fail++; $display("FAIL b2b_ctl c%0d: got %b%b", c, stall_o, wb_valid_o); end
            if (c == 3) begin
                n_checks++; if (rdata_o !== 32'h01020304) begin n_fail++; $display("FAIL b2b_rdata0: got %h want 01020304", rdata_o); end
            end
            if (c == 5) begin
                n_checks++; if (req_addr_o !== 32'h604) begin n_fail++; $display("FAIL b2b_addr1: got %h want 00000604", req_addr_o); end
            end
            if (c == 7) begin
                n_checks++; if (rdata_o !== 32'h000000CC) begin n_fail++; $display("FAIL b2b_rdata1: got %h want 000000cc", rdata_o); end
            end
        end
        drive_idle();
        last_load = 32'h000000CC;
    endtask

    task automatic test_misalign();
        logic [2:0]  v_f3   [2];
        logic [31:0] v_addr [2];
        logic [31:0] v_word [2];
        logic [31:0] v_exp  [2];
        v_f3   = '{3'b010, 3'b101};
        v_addr = '{32'h102, 32'h103};
        v_word = '{32'h0BADF00D, 32'hBEEF1234};
        v_exp  = '{32'h0BADF00D, 32'h0000BEEF};
        for (int i = 0; i < 2; i++) begin
            step();
            drive_op(16'h0008, v_f3[i], v_addr[i], 32'h0);
            drive_bus(1'b1, 1'b1, v_word[i]);
            @(negedge clk);
            n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL mis%0d_stall_c0: got %b want 1", i, stall_o); end
            step();
            @(negedge clk);
`ifdef LSU_MISALIGN_TRAP_EN
            n_checks++; if ({fault_o, wb_valid_o, req_valid_o, stall_o} !== 4'b1100) begin n_fail++; $display("FAIL mis%0d_trap: got %b%b%b%b want 1100", i, fault_o, wb_valid_o, req_valid_o, stall_o); end
            n_checks++; if (rdata_o !== last_load) begin n_fail++; $display("FAIL mis%0d_rdata_kept: got %h want %h", i, rdata_o, last_load); end
            step();
            drive_idle();
            @(negedge clk);
            n_checks++; if ({fault_o, wb_valid_o, state_o} !== {2'b00, ST_IDLE}) begin n_fail++; $display("FAIL mis%0d_after: got %b%b/%0d want 00/0", i, fault_o, wb_valid_o, state_o); end
`else
            n_checks++; if ({req_valid_o, req_addr_o} !== {1'b1, 32'h100}) begin n_fail++; $display("FAIL mis%0d_req: got %b %h want 1 00000100", i, req_valid_o, req_addr_o); end
            step();
            step();
            @(negedge clk);
            n_checks++; if ({wb_valid_o, rdata_o} !== {1'b1, v_exp[i]}) begin n_fail++; $display("FAIL mis%0d_rdata: got %b %h want 1 %h", i, wb_valid_o, rdata_o, v_exp[i]); end
            step();
            drive_idle();
            last_load = v_exp[i];
`endif
        end
    endtask

    task automatic test_mid_reset();
        step();
        drive_op(16'h0008, 3'b010, 32'h500, 32'h0);
        drive_bus(1'b1, 1'b0, 32'h0);
        step();
        step();
        rst_i = 1'b1;
        @(negedge clk);
        n_checks++; if (state_o !== ST_WAIT) begin n_fail++; $display("FAIL rst_mid_pre: got %0d want 2", state_o); end
        step();
        rst_i = 1'b0;
        drive_idle();
        drive_bus(1'b0, 1'b1, 32'h77777777);
        @(negedge clk);
        n_checks++; if ({stall_o, wb_valid_o, req_valid_o, req_we_o, req_wstrb_o, state_o} !== {8'h00, ST_IDLE}) begin n_fail++; $display("FAIL rst_mid_ctl: got %b%b%b%b %b %0d", stall_o, wb_valid_o, req_valid_o, req_we_o, req_wstrb_o, state_o); end
        n_checks++; if ({req_addr_o, req_wdata_o, rdata_o} !== 96'h0) begin n_fail++; $display("FAIL rst_mid_data: got %h %h %h want 0", req_addr_o, req_wdata_o, rdata_o); end
        step();
        drive_bus(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        n_checks++; if ({wb_valid_o, rdata_o, state_o} !== {1'b0, 32'h0, ST_IDLE}) begin n_fail++; $display("FAIL rst_mid_late_rsp: got %b %h %0d want 0 0 0", wb_valid_o, rdata_o, state_o); end
        step();
        @(negedge clk);
        n_checks++; if ({wb_valid_o, state_o} !== {1'b0, ST_IDLE}) begin n_fail++; $display("FAIL rst_mid_settle: got %b %0d want 0 0", wb_valid_o, state_o); end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        last_load = 32'h0;
        rst_i     = 1'b1;
        funct3_i  = 3'b000;
        addr_i    = 32'h0;
        wdata_i   = 32'h0;
        drive_idle();
        test_reset();
        test_no_start();
        test_lw();
        test_load_ext();
        test_store();
        test_stall();
        test_back_to_back();
        test_misalign();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
